// File: rtl/integer_divide_scheduler.sv
// Round-robin front end for one shared, fully pipelined integer divider.
// Requests are arbitrated and issued one per cycle. An in-order tag FIFO
// pairs each divider result with its requester. Results are then buffered
// in a response FIFO. A credit counter keeps the in-flight count plus the
// buffered count at or below FIFO_DEPTH. The divider cannot stall, so this
// is the only thing preventing the response FIFO from overflowing.
module integer_divide_scheduler #(
  parameter int WIDTH      = 32,
  parameter int NREQ       = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*WIDTH-1:0]       req_dividend,
  input  logic [NREQ*WIDTH-1:0]       req_divisor,
  output logic                        div_in_valid,
  output logic [WIDTH-1:0]            div_dividend,
  output logic [WIDTH-1:0]            div_divisor,
  input  logic                        div_out_valid,
  input  logic [WIDTH-1:0]            div_quotient,
  input  logic [WIDTH-1:0]            div_remainder,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [IDW-1:0]              rsp_id,
  output logic [WIDTH-1:0]            rsp_quotient,
  output logic [WIDTH-1:0]            rsp_remainder,
  output logic                        rsp_div_by_zero,
  output logic [$clog2(FIFO_DEPTH):0] credits_used,
  output logic                        err_orphan
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic           dbz;
    logic [IDW-1:0] id;
  } tag_t;

  typedef struct packed {
    tag_t             tag;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
  } rsp_t;

  logic [IDW-1:0] last, gnt_idx;
  logic           gnt_found, can_issue, issue;
  logic           tag_empty, tag_full, tag_pop;
  logic           rsp_full, rsp_push, rsp_pop;
  logic [WIDTH-1:0] sel_dividend, sel_divisor;

  tag_t          tag_mem [FIFO_DEPTH];
  logic [AW-1:0] tag_wp, tag_rp;
  logic [CW-1:0] tag_cnt;

  rsp_t          rsp_mem [FIFO_DEPTH];
  logic [AW-1:0] rsp_wp, rsp_rp;
  logic [CW-1:0] rsp_cnt;
  rsp_t          rsp_head, rsp_new;

  // Find the first valid requester, starting just after the last winner and wrapping
  always_comb begin : arb
    logic [IDW:0] j;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    j         = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = {1'b0, last} + (IDW+1)'(k);
      if (j >= (IDW+1)'(NREQ)) j = j - (IDW+1)'(NREQ);
      if (!gnt_found && req_valid[j[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = j[IDW-1:0];
      end
    end
  end

  assign can_issue    = credits_used < CW'(FIFO_DEPTH);
  assign issue        = gnt_found && can_issue;
  assign sel_dividend = req_dividend[gnt_idx*WIDTH +: WIDTH];
  assign sel_divisor  = req_divisor[gnt_idx*WIDTH +: WIDTH];

  // The grant is shown only while a credit is free, so ready implies issue
  always_comb begin
    req_ready = '0;
    if (issue) req_ready[gnt_idx] = 1'b1;
  end

  // Issue register: one-cycle strobe; operands hold their value while idle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last         <= IDW'(NREQ-1);
      div_in_valid <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      div_in_valid <= issue;
      if (issue) begin
        last         <= gnt_idx;
        div_dividend <= sel_dividend;
        div_divisor  <= sel_divisor;
      end
    end
  end

  assign tag_empty = (tag_cnt == '0);
  assign tag_full  = (tag_cnt == CW'(FIFO_DEPTH));
  assign tag_pop   = div_out_valid && !tag_empty;

  // Tag storage has no reset; only the pointers and the count define its contents
  always_ff @(posedge clk) begin
    if (issue) tag_mem[tag_wp] <= '{dbz: (sel_divisor == '0), id: gnt_idx};
  end

  // Tag FIFO pointers: one push per issue, one pop per returning result
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_wp  <= '0;
      tag_rp  <= '0;
      tag_cnt <= '0;
    end else begin
      if (issue)   tag_wp <= tag_wp + 1'b1;
      if (tag_pop) tag_rp <= tag_rp + 1'b1;
      tag_cnt <= tag_cnt + CW'(issue) - CW'(tag_pop);
    end
  end

  // A result with no matching tag is an orphan; it is dropped
  assign rsp_push = tag_pop;
  assign rsp_pop  = rsp_valid && rsp_ready;
  assign rsp_full = (rsp_cnt == CW'(FIFO_DEPTH));

  // Results of a divide by zero are forced to zero
  always_comb begin
    rsp_new.tag = tag_mem[tag_rp];
    rsp_new.q   = tag_mem[tag_rp].dbz ? '0 : div_quotient;
    rsp_new.r   = tag_mem[tag_rp].dbz ? '0 : div_remainder;
  end

  // Response FIFO: storage is cleared on reset, so the head ports read zero
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) rsp_mem[i] <= '0;
      rsp_wp  <= '0;
      rsp_rp  <= '0;
      rsp_cnt <= '0;
    end else begin
      if (rsp_push) begin
        rsp_mem[rsp_wp] <= rsp_new;
        rsp_wp          <= rsp_wp + 1'b1;
      end
      if (rsp_pop) rsp_rp <= rsp_rp + 1'b1;
      rsp_cnt <= rsp_cnt + CW'(rsp_push) - CW'(rsp_pop);
    end
  end

  assign rsp_head        = rsp_mem[rsp_rp];
  assign rsp_valid       = (rsp_cnt != '0);
  assign rsp_id          = rsp_head.tag.id;
  assign rsp_div_by_zero = rsp_head.tag.dbz;
  assign rsp_quotient    = rsp_head.q;
  assign rsp_remainder   = rsp_head.r;

  // Credits count operations inside the divider plus responses waiting in the buffer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credits_used <= '0;
      err_orphan   <= 1'b0;
    end else begin
      credits_used <= credits_used + CW'(issue) - CW'(rsp_pop);
      if (div_out_valid && tag_empty) err_orphan <= 1'b1;
    end
  end

  a_tag_ovf: assert property (@(posedge clk) disable iff (!rstn) !(issue && tag_full));
  a_rsp_ovf: assert property (@(posedge clk) disable iff (!rstn) !(rsp_push && rsp_full));

endmodule

// File: tb/tb_integer_divide_scheduler.sv
// Directed and random bench for integer_divide_scheduler with a behavioural
// WIDTH+2 stage divider model.
module tb_integer_divide_scheduler;
  localparam int WIDTH = 32, NREQ = 4, FIFO_DEPTH = 8, IDW = 2, L = WIDTH + 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req_valid, req_ready;
  logic [NREQ*WIDTH-1:0] req_dividend, req_divisor;
  logic                  div_in_valid, div_out_valid;
  logic [WIDTH-1:0]      div_dividend, div_divisor, div_quotient, div_remainder;
  logic                  rsp_valid, rsp_ready, rsp_div_by_zero, err_orphan;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_quotient, rsp_remainder;
  logic [3:0]            credits_used;

  integer_divide_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .div_in_valid(div_in_valid), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_out_valid(div_out_valid), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_div_by_zero(rsp_div_by_zero), .credits_used(credits_used), .err_orphan(err_orphan)
  );

  // Divider model: fixed latency L, no backpressure, optionally kept out of reset
  logic div_tie = 1'b0;
  logic div_rstn;
  assign div_rstn = div_tie ? 1'b1 : rstn;
  logic [L-1:0]     pv;
  logic [WIDTH-1:0] pq [L];
  logic [WIDTH-1:0] pr [L];
  always_ff @(posedge clk or negedge div_rstn) begin
    if (!div_rstn) pv <= '0;
    else begin
      pv    <= {pv[L-2:0], div_in_valid};
      pq[0] <= (div_divisor == 0) ? '1 : div_dividend / div_divisor;
      pr[0] <= (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
      for (int i = 1; i < L; i++) begin
        pq[i] <= pq[i-1];
        pr[i] <= pr[i-1];
      end
    end
  end
  assign div_out_valid = pv[L-1];
  assign div_quotient  = pq[L-1];
  assign div_remainder = pr[L-1];

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_dividend[i*WIDTH +: WIDTH] = a;
    req_divisor[i*WIDTH +: WIDTH]  = b;
  endtask

  // Wait (bounded) for a response, compare it, then pop it in one cycle
  task automatic get_rsp(input string tag, input logic [1:0] id, input logic [31:0] q,
                         input logic [31:0] r, input logic dbz);
    int n = 0;
    while (!rsp_valid && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_vld"}, rsp_valid, 1'b1);
    chk(tag, {rsp_id, rsp_div_by_zero, rsp_quotient, rsp_remainder}, {id, dbz, q, r});
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  typedef struct packed {
    logic [1:0]  id;
    logic        dbz;
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  logic [31:0] ea [4] = '{32'd100, 32'd1000, 32'd65535, 32'd17};
  logic [31:0] eb [4] = '{32'd7,   32'd33,   32'd256,   32'd20};
  logic [31:0] eq [4] = '{32'd14,  32'd30,   32'd255,   32'd0};
  logic [31:0] er [4] = '{32'd2,   32'd10,   32'd255,   32'd17};

  exp_t        sb [$];
  exp_t        e;
  int          n, bad_hot, guard;
  logic        seen;
  logic [31:0] a, b;

  initial begin
    req_valid = '0; req_dividend = '0; req_divisor = '0; rsp_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_div", {div_in_valid, div_dividend, div_divisor}, 65'd0);
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_div_by_zero, rsp_quotient, rsp_remainder}, 68'd0);
    chk("rst_cred", {credits_used, err_orphan}, 5'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    step();

    // Round robin: all valid, starting from requester 0, one issue per cycle
    for (int i = 0; i < 4; i++) set_op(i, ea[i], eb[i]);
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("rr_grant", req_ready, 4'b0001 << (k % 4));
      step();
      chk("rr_issue", {div_in_valid, div_dividend, div_divisor}, {1'b1, ea[k%4], eb[k%4]});
    end
    req_valid = '0;
    for (int k = 0; k < 8; k++) get_rsp("rr_rsp", 2'(k % 4), eq[k%4], er[k%4], 1'b0);
    chk("rr_cred", credits_used, 4'd0);

    // Single request, latency check: rsp_valid must rise in cycle 36
    set_op(2, 32'd100, 32'd7);
    req_valid = 4'b0100;
    #1;
    chk("one_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    chk("one_issue", {div_in_valid, div_dividend, div_divisor, credits_used},
        {1'b1, 32'd100, 32'd7, 4'd1});
    step();
    chk("one_pulse", div_in_valid, 1'b0);
    repeat (33) step();
    chk("one_early", rsp_valid, 1'b0);
    step();
    chk("one_lat", rsp_valid, 1'b1);
    get_rsp("one_rsp", 2'd2, 32'd14, 32'd2, 1'b0);

    // Divide by zero
    set_op(0, 32'd55, 32'd0);
    req_valid = 4'b0001;
    #1;
    step();
    req_valid = '0;
    get_rsp("dbz_rsp", 2'd0, 32'd0, 32'd0, 1'b1);

    // Backpressure: credits stop issue at FIFO_DEPTH
    set_op(1, 32'd81, 32'd9);
    req_valid = 4'b0010;
    n = 0;
    for (int c = 0; c < 45; c++) begin
      #1;
      if (req_ready != 0) n++;
      step();
    end
    chk("bp_issues", n, 8);
    chk("bp_full", {credits_used, req_ready}, {4'd8, 4'b0000});
    chk("bp_rspv", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    #1;
    chk("bp_block", req_ready, 4'b0000);
    step();
    rsp_ready = 1'b0;
    #1;
    chk("bp_free", {credits_used, req_ready}, {4'd7, 4'b0010});
    step();
    chk("bp_reissue", {div_in_valid, credits_used}, {1'b1, 4'd8});
    #1;
    chk("bp_again", req_ready, 4'b0000);
    req_valid = '0;
    for (int k = 0; k < 8; k++) get_rsp("bp_rsp", 2'd1, 32'd9, 32'd0, 1'b0);
    chk("bp_drain", credits_used, 4'd0);

    // Reset mid-flight, divider reset too: nothing emerges, no orphan
    for (int v = 0; v < 2; v++) begin
      div_tie = (v == 1);
      set_op(3, 32'd50, 32'd5);
      req_valid = 4'b1000;
      repeat (5) step();
      req_valid = '0;
      repeat (3) step();
      chk("mid_cred", credits_used, 4'd5);
      rstn = 1'b0;
      #1;
      chk("mid_rst", {req_ready, div_in_valid, div_dividend, div_divisor, rsp_valid, credits_used},
          {4'b0000, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0});
      step();
      rstn = 1'b1;
      seen = 1'b0;
      repeat (50) begin
        step();
        if (rsp_valid) seen = 1'b1;
      end
      chk("mid_norsp", {seen, credits_used}, {1'b0, 4'd0});
      chk("mid_orphan", err_orphan, (v == 1) ? 1'b1 : 1'b0);
    end
    div_tie = 1'b0;
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    chk("orphan_clr", err_orphan, 1'b0);

    // Random soak with an in-order scoreboard
    bad_hot = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 4; i++) begin
        a = $urandom;
        if ($urandom_range(0, 7) == 0) b = 0;
        else if ($urandom_range(0, 1) == 1) b = $urandom_range(1, 300);
        else b = $urandom;
        set_op(i, a, b);
      end
      req_valid = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (!$onehot0(req_ready)) bad_hot++;
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          a = req_dividend[i*WIDTH +: WIDTH];
          b = req_divisor[i*WIDTH +: WIDTH];
          e.id = 2'(i);
          e.dbz = (b == 0);
          e.q = (b == 0) ? 32'd0 : a / b;
          e.r = (b == 0) ? 32'd0 : a % b;
          sb.push_back(e);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) chk("soak_extra", 1'b1, 1'b0);
        else begin
          e = sb.pop_front();
          chk("soak_rsp", {rsp_id, rsp_div_by_zero, rsp_quotient, rsp_remainder}, e);
        end
      end
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    guard = 0;
    while ((sb.size() != 0 || credits_used != 0) && guard < 300) begin
      #1;
      if (rsp_valid) begin
        if (sb.size() == 0) chk("soak_extra", 1'b1, 1'b0);
        else begin
          e = sb.pop_front();
          chk("soak_rsp", {rsp_id, rsp_div_by_zero, rsp_quotient, rsp_remainder}, e);
        end
      end
      step();
      guard++;
    end
    chk("soak_idle", {credits_used, rsp_valid, err_orphan}, 6'd0);
    chk("soak_sb", sb.size(), 0);
    chk("soak_onehot", bad_hot, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
